// File: rtl/kbd_mmio_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kbd_mmio_responder_pkg                                                     |
// | Shared io constants: keyboard address region, register map, FSM states.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package kbd_mmio_responder_pkg;

    localparam logic [3:0] KBD_REGION     = 4'he;
    localparam logic [1:0] KBD_REG_DATA   = 2'd0;
    localparam logic [1:0] KBD_REG_STATUS = 2'd1;
    localparam logic [1:0] KBD_REG_CTRL   = 2'd2;

    typedef enum logic [0:0] {
        KBD_IDLE = 1'b0,
        KBD_ACK  = 1'b1
    } kbd_state_e;

    // frame[0]=start, frame[8:1]=data LSB first, frame[9]=odd parity, frame[10]=stop
    function automatic logic ps2_frame_ok(input logic [10:0] frame);
        return (frame[0] == 1'b0) && frame[10] && (^frame[9:1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_mmio_responder_ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ps2_rx                                                                     |
// | PS/2 synchronizer, falling-edge detect, 11-bit frame shifter and timeout.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ps2_rx
    import kbd_mmio_responder_pkg::*;
#(
    parameter int TIMEOUT = 20000
) (
    input  logic       ui_clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       push_o,
    output logic [7:0] code_o,
    output logic       err_o
);

    localparam int             TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMEOUT_CNT = TW'(TIMEOUT);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          clk_prev_q;
    logic [9:0]    shift_q;
    logic [3:0]    bit_cnt_q;
    logic [TW-1:0] timer_q;
    logic          push_q;
    logic          err_q;
    logic [7:0]    code_q;

    logic          fall;
    logic [10:0]   frame;

    assign fall  = clk_prev_q & ~clk_sync_q[1];
    // The stop bit arrives with the final edge, so the frame is assembled on the fly
    assign frame = {data_sync_q[1], shift_q};

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            timer_q     <= '0;
            push_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[1];
            push_q      <= 1'b0;
            err_q       <= 1'b0;
            if (fall) begin
                timer_q <= '0;
                if (bit_cnt_q == 4'd10) begin
                    bit_cnt_q <= '0;
                    push_q    <= ps2_frame_ok(frame);
                    err_q     <= ~ps2_frame_ok(frame);
                    code_q    <= frame[8:1];
                end else begin
                    shift_q   <= {data_sync_q[1], shift_q[9:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end
            end else if (timer_q == TIMEOUT_CNT) begin
                // Saturated: abandon any partial frame
                bit_cnt_q <= '0;
            end else begin
                timer_q <= timer_q + TW'(1);
            end
        end
    end

    assign push_o = push_q;
    assign err_o  = err_q;
    assign code_o = code_q;

endmodule
`default_nettype wire

// File: rtl/kbd_mmio_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | kbd_mmio_responder                                                         |
// | Memory-mapped PS/2 keyboard: scancode FIFO, STATUS/CTRL, DATA-read FSM.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module kbd_mmio_responder
    import kbd_mmio_responder_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 20000
) (
    input  logic        ui_clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        dmem_read_in,
    input  logic        dmem_write_in,
    input  logic [29:0] dmem_addr,
    input  logic [31:0] data_from_reg,
    input  logic        ext_stall,
    output logic [31:0] dmem_data_out,
    output logic        kbd_stall,
    output logic        kbd_nonempty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          rx_push;
    logic          rx_err;
    logic [7:0]    rx_code;

    ps2_rx #(
        .TIMEOUT   (TIMEOUT)
    ) u_ps2_rx (
        .ui_clk    (ui_clk),
        .rst       (rst),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .push_o    (rx_push),
        .code_o    (rx_code),
        .err_o     (rx_err)
    );

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          parity_err_q, parity_err_d;
    kbd_state_e    state_q, state_d;
    logic [31:0]   rd_data_q, rd_data_d;

    logic          sel;
    logic          data_rd;
    logic          status_clr;
    logic          flush;
    logic          nonempty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovf_set;
    logic          stall;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign sel        = (dmem_addr[29:26] == KBD_REGION);
    assign data_rd    = sel & dmem_read_in & (dmem_addr[1:0] == KBD_REG_DATA);
    assign status_clr = sel & dmem_write_in & (dmem_addr[1:0] == KBD_REG_STATUS) & data_from_reg[0];
    assign flush      = sel & dmem_write_in & (dmem_addr[1:0] == KBD_REG_CTRL) & data_from_reg[0];
    assign nonempty   = (count_q != '0);
    assign full       = (count_q == CW'(DEPTH));

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign do_push = rx_push & ~flush & (~full | do_pop);
    assign ovf_set = rx_push & ~flush & full & ~do_pop;

    assign unused_bits = ^{dmem_addr[25:2], data_from_reg[31:1]};

    always_comb begin
        state_d   = state_q;
        rd_data_d = rd_data_q;
        stall     = 1'b0;
        do_pop    = 1'b0;
        case (state_q)
            KBD_IDLE: begin
                if (data_rd) begin
                    stall     = 1'b1;
                    do_pop    = nonempty;
                    rd_data_d = nonempty ? {23'd0, 1'b1, mem_q[rd_ptr_q]} : 32'd0;
                    state_d   = KBD_ACK;
                end
            end
            KBD_ACK: begin
                if (!ext_stall) begin
                    state_d = KBD_IDLE;
                end
            end
            default: state_d = KBD_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // New errors in the clearing cycle must survive the clear
    assign overflow_d   = (overflow_q & ~status_clr) | ovf_set;
    assign parity_err_d = (parity_err_q & ~status_clr) | rx_err;

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            state_q      <= KBD_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            parity_err_q <= parity_err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= rx_code;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel && dmem_read_in) begin
            case (dmem_addr[1:0])
                KBD_REG_DATA: begin
                    if (state_q == KBD_ACK) rdata = rd_data_q;
                end
                KBD_REG_STATUS: rdata = {24'd0, 5'(count_q), overflow_q, parity_err_q, nonempty};
                default:        rdata = '0;
            endcase
        end
    end

    assign dmem_data_out = rst ? rdata : 32'd0;
    assign kbd_stall     = rst & stall;
    assign kbd_nonempty  = rst & nonempty;

endmodule
`default_nettype wire

// File: tb/tb_kbd_mmio_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_kbd_mmio_responder                                                      |
// | Self-checking bench: PS/2 frame driver, MMIO tasks, queue reference model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_kbd_mmio_responder;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 300;
    localparam int HALF    = 4;

    logic        ui_clk        = 1'b0;
    logic        rst           = 1'b0;
    logic        ps2_clk       = 1'b1;
    logic        ps2_data      = 1'b1;
    logic        dmem_read_in  = 1'b0;
    logic        dmem_write_in = 1'b0;
    logic [29:0] dmem_addr     = '0;
    logic [31:0] data_from_reg = '0;
    logic        ext_stall     = 1'b0;
    logic [31:0] dmem_data_out;
    logic        kbd_stall;
    logic        kbd_nonempty;

    int checks = 0;
    int fails  = 0;

    logic [7:0] model_q[$];
    bit         m_ovf  = 1'b0;
    bit         m_perr = 1'b0;

    always #5 ui_clk = ~ui_clk;

    kbd_mmio_responder #(
        .DEPTH        (DEPTH),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .ui_clk       (ui_clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .dmem_read_in (dmem_read_in),
        .dmem_write_in(dmem_write_in),
        .dmem_addr    (dmem_addr),
        .data_from_reg(data_from_reg),
        .ext_stall    (ext_stall),
        .dmem_data_out(dmem_data_out),
        .kbd_stall    (kbd_stall),
        .kbd_nonempty (kbd_nonempty)
    );

    // ---------------- reference model ----------------
    function automatic void m_frame(input logic [7:0] c, input bit bad);
        if (bad) m_perr = 1'b1;
        else if (model_q.size() < DEPTH) model_q.push_back(c);
        else m_ovf = 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        return {24'd0, 5'(model_q.size()), m_ovf, m_perr, model_q.size() != 0};
    endfunction

    function automatic logic [31:0] m_pop();
        logic [7:0] c;
        if (model_q.size() == 0) return 32'd0;
        c = model_q.pop_front();
        return {23'd0, 1'b1, c};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic idle_bus();
        dmem_read_in  = 1'b0;
        dmem_write_in = 1'b0;
        dmem_addr     = '0;
        data_from_reg = '0;
    endtask

    function automatic logic [29:0] kaddr(input logic [1:0] r);
        return {4'he, 24'd0, r};
    endfunction

    function automatic logic [10:0] mkframe(input logic [7:0] c, input bit bad_par);
        return {1'b1, (~^c) ^ bad_par, c, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            repeat (HALF) step();
            ps2_clk = 1'b0;
            repeat (HALF) step();
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) step();
    endtask

    task automatic send(input logic [7:0] c, input bit bad);
        ps2_bits(mkframe(c, bad), 11);
        m_frame(c, bad);
    endtask

    task automatic data_read(output logic [31:0] d, output int stalls);
        dmem_addr    = kaddr(2'd0);
        dmem_read_in = 1'b1;
        stalls       = 0;
        @(negedge ui_clk);
        while (kbd_stall === 1'b1 && stalls < 10) begin
            stalls++;
            step();
            @(negedge ui_clk);
        end
        d = dmem_data_out;
        step();
        idle_bus();
    endtask

    task automatic status_read(output logic [31:0] d, output logic stl);
        dmem_addr    = kaddr(2'd1);
        dmem_read_in = 1'b1;
        @(negedge ui_clk);
        d   = dmem_data_out;
        stl = kbd_stall;
        step();
        idle_bus();
    endtask

    task automatic reg_write(input logic [1:0] r, input logic [31:0] v, output logic stl);
        dmem_addr     = kaddr(r);
        dmem_write_in = 1'b1;
        data_from_reg = v;
        @(negedge ui_clk);
        stl = kbd_stall;
        step();
        idle_bus();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] d;
        logic        s;
        rst          = 1'b0;
        dmem_addr    = kaddr(2'd1);
        dmem_read_in = 1'b1;
        repeat (3) step();
        @(negedge ui_clk);
        checks++;
        if (kbd_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", kbd_stall); end
        checks++;
        if (kbd_nonempty !== 1'b0) begin fails++; $display("FAIL reset_nonempty: got %b expected 0", kbd_nonempty); end
        checks++;
        if (dmem_data_out !== 32'd0) begin fails++; $display("FAIL reset_data: got %h expected 0", dmem_data_out); end
        step();
        rst = 1'b1;
        idle_bus();
        step();
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL reset_status: got %h expected %h", d, m_status()); end
    endtask

    task automatic test_single_frame();
        logic [31:0] d, e;
        logic        s;
        int          n;
        send(8'h1C, 1'b0);
        checks++;
        if (kbd_nonempty !== 1'b1) begin fails++; $display("FAIL single_nonempty: got %b expected 1", kbd_nonempty); end
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL single_status: got %h expected %h", d, m_status()); end
        checks++;
        if (s !== 1'b0) begin fails++; $display("FAIL status_nostall: got %b expected 0", s); end
        e = m_pop();
        data_read(d, n);
        checks++;
        if (n !== 1) begin fails++; $display("FAIL single_stall_cycles: got %0d expected 1", n); end
        checks++;
        if (d !== e) begin fails++; $display("FAIL single_data: got %h expected %h", d, e); end
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL single_status_after: got %h expected %h", d, m_status()); end
    endtask

    task automatic test_parity_err();
        logic [31:0] d;
        logic        s;
        send(8'h1C, 1'b1);
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL parity_status: got %h expected %h", d, m_status()); end
        reg_write(2'd1, 32'd1, s);
        m_perr = 1'b0;
        m_ovf  = 1'b0;
        checks++;
        if (s !== 1'b0) begin fails++; $display("FAIL write_nostall: got %b expected 0", s); end
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL parity_cleared: got %h expected %h", d, m_status()); end
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        logic        s;
        int          n;
        for (int c = 1; c <= 17; c++) send(8'(c), 1'b0);
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL ovf_status: got %h expected %h", d, m_status()); end
        for (int i = 0; i < 17; i++) begin
            e = m_pop();
            data_read(d, n);
            checks++;
            if (d !== e || n !== 1) begin
                fails++;
                $display("FAIL ovf_read%0d: got %h/%0d stalls expected %h/1", i, d, n, e);
            end
        end
        reg_write(2'd1, 32'd1, s);
        m_perr = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic test_ext_stall();
        logic [31:0] d, e;
        logic        s;
        int          n;
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        dmem_addr    = kaddr(2'd0);
        dmem_read_in = 1'b1;
        @(negedge ui_clk);
        checks++;
        if (kbd_stall !== 1'b1) begin fails++; $display("FAIL xstall_first: got %b expected 1", kbd_stall); end
        step();
        ext_stall = 1'b1;
        e = m_pop();
        for (int i = 0; i < 5; i++) begin
            @(negedge ui_clk);
            checks++;
            if (dmem_data_out !== e || kbd_stall !== 1'b0) begin
                fails++;
                $display("FAIL xstall_hold%0d: got %h stall %b expected %h stall 0", i, dmem_data_out, kbd_stall, e);
            end
            step();
        end
        ext_stall = 1'b0;
        step();
        idle_bus();
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL xstall_onepop: got %h expected %h", d, m_status()); end
        e = m_pop();
        data_read(d, n);
        checks++;
        if (d !== e) begin fails++; $display("FAIL xstall_next: got %h expected %h", d, e); end
    endtask

    task automatic test_timeout();
        logic [31:0] d, e;
        logic        s;
        int          n;
        ps2_bits(mkframe(8'h77, 1'b0), 5);
        repeat (TIMEOUT + 10) step();
        send(8'h5A, 1'b0);
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL timeout_status: got %h expected %h", d, m_status()); end
        e = m_pop();
        data_read(d, n);
        checks++;
        if (d !== e) begin fails++; $display("FAIL timeout_data: got %h expected %h", d, e); end
    endtask

    task automatic test_flush_and_decode();
        logic [31:0] d;
        logic        s;
        send(8'($urandom_range(0, 255)), 1'b0);
        send(8'($urandom_range(0, 255)), 1'b0);
        reg_write(2'd2, 32'd0, s);
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL ctrl_noflush: got %h expected %h", d, m_status()); end
        reg_write(2'd2, 32'd1, s);
        model_q.delete();
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL flush_status: got %h expected %h", d, m_status()); end
        dmem_addr    = kaddr(2'd3);
        dmem_read_in = 1'b1;
        @(negedge ui_clk);
        checks++;
        if (dmem_data_out !== 32'd0 || kbd_stall !== 1'b0) begin
            fails++; $display("FAIL reserved_read: got %h stall %b expected 0", dmem_data_out, kbd_stall);
        end
        step();
        dmem_addr = {4'h3, 24'd0, 2'd1};
        @(negedge ui_clk);
        checks++;
        if (dmem_data_out !== 32'd0) begin fails++; $display("FAIL unselected_read: got %h expected 0", dmem_data_out); end
        step();
        idle_bus();
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic        s;
        int          n;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0, 1: send(8'($urandom_range(0, 255)), 1'b0);
                2: send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
                3: begin
                    e = m_pop();
                    data_read(d, n);
                    checks++;
                    if (d !== e || n !== 1) begin
                        fails++; $display("FAIL rand_data%0d: got %h/%0d expected %h/1", k, d, n, e);
                    end
                end
                4: begin
                    status_read(d, s);
                    checks++;
                    if (d !== m_status()) begin fails++; $display("FAIL rand_status%0d: got %h expected %h", k, d, m_status()); end
                end
                default: begin
                    reg_write(2'd1, 32'd1, s);
                    m_ovf  = 1'b0;
                    m_perr = 1'b0;
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d, e;
        logic        s;
        int          n;
        send(8'h12, 1'b0);
        ps2_bits(mkframe(8'h65, 1'b0), 3);
        dmem_addr    = kaddr(2'd0);
        dmem_read_in = 1'b1;
        @(negedge ui_clk);
        step();
        rst = 1'b0;
        @(negedge ui_clk);
        checks++;
        if (dmem_data_out !== 32'd0 || kbd_stall !== 1'b0 || kbd_nonempty !== 1'b0) begin
            fails++;
            $display("FAIL midreset_outputs: got %h/%b/%b expected 0/0/0", dmem_data_out, kbd_stall, kbd_nonempty);
        end
        step();
        rst = 1'b1;
        idle_bus();
        model_q.delete();
        m_ovf  = 1'b0;
        m_perr = 1'b0;
        step();
        send(8'h29, 1'b0);
        status_read(d, s);
        checks++;
        if (d !== m_status()) begin fails++; $display("FAIL midreset_status: got %h expected %h", d, m_status()); end
        e = m_pop();
        data_read(d, n);
        checks++;
        if (d !== e) begin fails++; $display("FAIL midreset_data: got %h expected %h", d, e); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity_err();
        test_overflow();
        test_ext_stall();
        test_timeout();
        test_flush_and_decode();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
